pc_sequencer: RTL and testbench

Parametrised program-counter sequencer that replaces the single-increment PC with a full fetch-address generator. Each cycle it selects the next instruction address from a priority-ordered set of sources: exception vector, absolute jump, return-address pop, PC-relative branch, or sequential step. It holds an internal return-address stack (RAS) for call/return, and a small boot/run/halt state machine. It drives the instruction-memory address and sits between the decode/branch logic and imem.

---
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address generator with a return-address stack.
//
// Each cycle the next fetch address is chosen from (highest priority first):
// exception vector, absolute jump (optionally pushing a return address),
// return-address pop, PC-relative branch, or a sequential step. A small
// BOOT/RUN/HALTED state machine gates whether pc is a real fetch.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_stall          hold pc (does not block an exception)
//   i_halt           request entry to HALTED
//   i_exc_valid      exception redirect to i_exc_vector
//   i_jump_valid     absolute redirect to i_jump_target
//   i_call           with i_jump_valid: push pc+STEP
//   i_ret            pop the RAS and redirect to the popped address
//   i_branch_valid   redirect to pc + i_branch_offset (signed, address units)
//   i_clear_flags    clear the sticky RAS flags
//   o_pc             current fetch address (registered)
//   o_pc_valid       high only in RUN
//   o_pc_plus_step   o_pc + STEP
//   o_ras_count      live RAS entries
//   o_ras_overflow   sticky: push while full
//   o_ras_underflow  sticky: pop while empty

module pc_sequencer #(
    parameter int                WIDTH        = 32,
    parameter int                STEP         = 1,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_stall,
    input  logic                         i_halt,
    input  logic                         i_exc_valid,
    input  logic [WIDTH-1:0]             i_exc_vector,
    input  logic                         i_jump_valid,
    input  logic [WIDTH-1:0]             i_jump_target,
    input  logic                         i_call,
    input  logic                         i_ret,
    input  logic                         i_branch_valid,
    input  logic [WIDTH-1:0]             i_branch_offset,
    input  logic                         i_clear_flags,
    output logic [WIDTH-1:0]             o_pc,
    output logic                         o_pc_valid,
    output logic [WIDTH-1:0]             o_pc_plus_step,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
    output logic                         o_ras_overflow,
    output logic                         o_ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_pc;
    logic [WIDTH-1:0]  w_next_pc;
    logic [WIDTH-1:0]  w_pc_plus_step;

    // Circular LIFO: r_wp is the slot the next push writes, so the top of
    // stack lives one below it. Power-of-two depth lets the pointer wrap for
    // free, which is what makes an overflowing push overwrite the oldest entry.
    logic [WIDTH-1:0]  r_ras [RAS_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     w_top_idx;
    logic [CW-1:0]     r_count;
    logic              r_oflow;
    logic              r_uflow;

    logic              w_push;
    logic              w_pop;
    logic              w_oflow_set;
    logic              w_uflow_set;

    assign w_pc_plus_step = r_pc + WIDTH'(STEP);
    assign w_top_idx      = r_wp - PW'(1);
    assign w_oflow_set    = w_push && (r_count == CW'(RAS_DEPTH));

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_uflow_set  = 1'b0;
        case (r_state)
            S_BOOT: w_next_state = S_RUN;
            S_RUN: begin
                if (i_exc_valid) begin
                    w_next_pc = i_exc_vector;
                end else begin
                    if (i_stall) begin
                        w_next_pc = r_pc;
                    end else if (i_jump_valid) begin
                        w_next_pc = i_jump_target;
                        w_push    = i_call;
                    end else if (i_ret) begin
                        if (r_count != '0) begin
                            w_next_pc = r_ras[w_top_idx];
                            w_pop     = 1'b1;
                        end else begin
                            w_next_pc   = w_pc_plus_step;
                            w_uflow_set = 1'b1;
                        end
                    end else if (i_branch_valid) begin
                        w_next_pc = r_pc + i_branch_offset;
                    end else begin
                        w_next_pc = w_pc_plus_step;
                    end
                    // Whatever redirect was chosen above still lands this cycle.
                    if (i_halt) w_next_state = S_HALTED;
                end
            end
            S_HALTED: begin
                if (i_exc_valid) begin
                    w_next_pc    = i_exc_vector;
                    w_next_state = S_RUN;
                end
            end
            default: w_next_state = S_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_count <= '0;
            r_oflow <= 1'b0;
            r_uflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PW'(1);
                if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + CW'(1);
            end else if (w_pop) begin
                r_wp    <= w_top_idx;
                r_count <= r_count - CW'(1);
            end
            // A set event in the same cycle as clear_flags must win.
            if (w_oflow_set)        r_oflow <= 1'b1;
            else if (i_clear_flags) r_oflow <= 1'b0;
            if (w_uflow_set)        r_uflow <= 1'b1;
            else if (i_clear_flags) r_uflow <= 1'b0;
        end
    end

    // Storage needs no reset: r_count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) r_ras[r_wp] <= w_pc_plus_step;
    end

    assign o_pc            = r_pc;
    assign o_pc_valid      = (r_state == S_RUN);
    assign o_pc_plus_step  = w_pc_plus_step;
    assign o_ras_count     = r_count;
    assign o_ras_overflow  = r_oflow;
    assign o_ras_underflow = r_uflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a queue-based reference model updated on every
// clock edge, a compare process checking all outputs on each falling edge,
// and directed scenarios with literal expectations.

module tb_pc_sequencer;

    localparam int          W    = 32;
    localparam int          DEP  = 4;
    localparam logic [31:0] RV   = 32'h100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall, halt, exc_valid, jump_valid, call, ret, branch_valid, clear_flags;
    logic [31:0]  exc_vector, jump_target, branch_offset;
    logic [31:0]  pc, pc_plus_step;
    logic         pc_valid, ras_overflow, ras_underflow;
    logic [2:0]   ras_count;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.WIDTH(W), .STEP(1), .RESET_VECTOR(RV), .RAS_DEPTH(DEP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_halt(halt),
        .i_exc_valid(exc_valid), .i_exc_vector(exc_vector),
        .i_jump_valid(jump_valid), .i_jump_target(jump_target),
        .i_call(call), .i_ret(ret),
        .i_branch_valid(branch_valid), .i_branch_offset(branch_offset),
        .i_clear_flags(clear_flags),
        .o_pc(pc), .o_pc_valid(pc_valid), .o_pc_plus_step(pc_plus_step),
        .o_ras_count(ras_count), .o_ras_overflow(ras_overflow),
        .o_ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=BOOT 1=RUN 2=HALTED; RAS is a plain queue, oldest
    // entry at the front, trimmed to DEP entries after each push.
    int          m_state = 0;
    logic [31:0] m_pc    = RV;
    logic [31:0] m_ras[$];
    bit          m_of    = 1'b0;
    bit          m_uf    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit of_set, uf_set;
        of_set = 1'b0;
        uf_set = 1'b0;
        if (!rst_n) begin
            m_state = 0; m_pc = RV; m_ras.delete(); m_of = 1'b0; m_uf = 1'b0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (exc_valid) m_pc = exc_vector;
                    else begin
                        if (!stall) begin
                            if (jump_valid) begin
                                if (call) begin
                                    m_ras.push_back(m_pc + 32'd1);
                                    if (m_ras.size() > DEP) begin
                                        void'(m_ras.pop_front());
                                        of_set = 1'b1;
                                    end
                                end
                                m_pc = jump_target;
                            end else if (ret) begin
                                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                                else begin m_pc = m_pc + 32'd1; uf_set = 1'b1; end
                            end else if (branch_valid) m_pc = m_pc + branch_offset;
                            else m_pc = m_pc + 32'd1;
                        end
                        if (halt) m_state = 2;
                    end
                end
                default: if (exc_valid) begin m_pc = exc_vector; m_state = 1; end
            endcase
            if (clear_flags) begin m_of = 1'b0; m_uf = 1'b0; end
            if (of_set) m_of = 1'b1;
            if (uf_set) m_uf = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("model_pc",       pc,                   m_pc);
        chk("model_valid",    {31'd0, pc_valid},    {31'd0, m_state == 1});
        chk("model_plusstep", pc_plus_step,         m_pc + 32'd1);
        chk("model_count",    {29'd0, ras_count},   m_ras.size());
        chk("model_oflow",    {31'd0, ras_overflow},  {31'd0, m_of});
        chk("model_uflow",    {31'd0, ras_underflow}, {31'd0, m_uf});
    end

    task automatic idle();
        stall = 0; halt = 0; exc_valid = 0; jump_valid = 0; call = 0; ret = 0;
        branch_valid = 0; clear_flags = 0;
        exc_vector = '0; jump_target = '0; branch_offset = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_jump(input logic [31:0] t, input logic c);
        jump_valid = 1; jump_target = t; call = c;
        cyc();
        idle();
    endtask

    initial begin
        logic [31:0] rets [5];
        rets = '{32'h501, 32'h401, 32'h301, 32'h201, 32'h202};
        rst_n = 0;
        idle();
        repeat (2) cyc();
        chk("reset_pc",    pc,                 32'h100);
        chk("reset_valid", {31'd0, pc_valid},  32'd0);
        chk("reset_count", {29'd0, ras_count}, 32'd0);
        rst_n = 1;
        cyc();
        chk("boot_pc",    pc,                32'h100);
        chk("boot_valid", {31'd0, pc_valid}, 32'd1);
        cyc(); chk("step1", pc, 32'h101);
        cyc(); chk("step2", pc, 32'h102);
        // Asynchronous reset between edges.
        #3 rst_n = 0;
        #1 chk("async_rst_pc", pc, 32'h100);
        chk("async_rst_valid", {31'd0, pc_valid}, 32'd0);
        cyc();
        rst_n = 1;
        cyc();

        // Negative branch and wrap-around.
        do_jump(32'h20, 1'b0);
        chk("jump_20", pc, 32'h20);
        branch_valid = 1; branch_offset = 32'hFFFF_FFFC;
        cyc(); idle();
        chk("branch_neg", pc, 32'h1C);
        do_jump(32'hFFFF_FFFF, 1'b0);
        cyc();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_plus", pc_plus_step, 32'h1);

        // Call / return.
        do_jump(32'h10, 1'b0);
        do_jump(32'h80, 1'b1);
        chk("call_pc",    pc,                 32'h80);
        chk("call_count", {29'd0, ras_count}, 32'd1);
        cyc(); cyc();
        chk("pre_ret_pc", pc, 32'h82);
        ret = 1; cyc(); idle();
        chk("ret_pc",    pc,                 32'h11);
        chk("ret_count", {29'd0, ras_count}, 32'd0);

        // Five nested calls on a four-deep stack.
        do_jump(32'h200, 1'b1);
        do_jump(32'h300, 1'b1);
        do_jump(32'h400, 1'b1);
        do_jump(32'h500, 1'b1);
        do_jump(32'h600, 1'b1);
        chk("ovf_flag",  {31'd0, ras_overflow}, 32'd1);
        chk("ovf_count", {29'd0, ras_count},    32'd4);
        for (int i = 0; i < 5; i++) begin
            ret = 1; cyc(); idle();
            chk($sformatf("ret_%0d", i), pc, rets[i]);
        end
        chk("uflow_flag", {31'd0, ras_underflow}, 32'd1);
        // Set beats clear in the same cycle.
        ret = 1; clear_flags = 1; cyc(); idle();
        chk("set_wins_uflow", {31'd0, ras_underflow}, 32'd1);
        chk("set_wins_oflow", {31'd0, ras_overflow},  32'd0);
        clear_flags = 1; cyc(); idle();
        chk("clear_uflow", {31'd0, ras_underflow}, 32'd0);

        // Stall holds against branch; exception overrides stall.
        do_jump(32'h40, 1'b0);
        stall = 1; branch_valid = 1; branch_offset = 32'h8;
        cyc(); chk("stall_1", pc, 32'h40);
        cyc(); chk("stall_2", pc, 32'h40);
        exc_valid = 1; exc_vector = 32'h8;
        cyc(); idle();
        chk("exc_over_stall", pc, 32'h8);

        // Halt, ignored inputs, exception exit.
        do_jump(32'h50, 1'b0);
        halt = 1; cyc(); idle();
        chk("halt_pc",    pc,                32'h51);
        chk("halt_valid", {31'd0, pc_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            jump_valid = 1; jump_target = 32'h999; call = 1; ret = 1; branch_valid = 1;
            branch_offset = 32'h4;
            cyc(); idle();
            chk($sformatf("halted_hold_%0d", i), pc, 32'h51);
        end
        exc_valid = 1; exc_vector = 32'h4; cyc(); idle();
        chk("halt_exit_pc",    pc,                32'h4);
        chk("halt_exit_valid", {31'd0, pc_valid}, 32'd1);
        cyc(); chk("run_again", pc, 32'h5);

        // Halt together with a jump: jump lands, state goes HALTED.
        halt = 1; jump_valid = 1; jump_target = 32'h70; cyc(); idle();
        chk("halt_jump_pc",    pc,                32'h70);
        chk("halt_jump_valid", {31'd0, pc_valid}, 32'd0);
        // Halt with exception stays in RUN.
        exc_valid = 1; exc_vector = 32'h30; cyc(); idle();
        halt = 1; exc_valid = 1; exc_vector = 32'h60; cyc(); idle();
        chk("halt_exc_pc",    pc,                32'h60);
        chk("halt_exc_valid", {31'd0, pc_valid}, 32'd1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
